// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Contents: bus count and field widths, the writeback entry struct carried on
// each result bus, and default source count / per-source queue depth.
package wb_arbiter_pkg;

  localparam int NUM_WB     = 3;   // number of writeback buses
  localparam int VREG_W     = 5;   // vreg tag width
  localparam int XLEN       = 32;  // result data width
  localparam int DEF_NSRC   = 4;   // ALU, MUL, DIV, LSB
  localparam int DEF_QDEPTH = 4;

  typedef struct packed {
    logic              en;
    logic [VREG_W-1:0] vregid;
    logic [XLEN-1:0]   val;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result queue for the writeback arbiter.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous clear of all entries
//   push, push_vregid,
//   push_val             enqueue request and its data
//   pop                  dequeue the head (only meaningful when non-empty)
//   head_vregid,head_val combinational view of the oldest entry
//   count                registered occupancy
//   afull                count >= QDEPTH-1
//   overflow             pulse: push while full with no pop (result dropped)
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [VREG_W-1:0]           push_vregid,
  input  logic [XLEN-1:0]             push_val,
  input  logic                        pop,
  output logic [VREG_W-1:0]           head_vregid,
  output logic [XLEN-1:0]             head_val,
  output logic [$clog2(QDEPTH):0]     count,
  output logic                        afull,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [VREG_W-1:0] mem_vregid [QDEPTH];
  logic [XLEN-1:0]   mem_val    [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(QDEPTH));
  // A pop in the same cycle frees the slot the push lands in, so a full
  // queue still accepts a push when its head is being granted.
  assign do_pop   = pop && (count != '0) && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign overflow = push && full && !do_pop && !flush;
  assign afull    = (count >= CNT_W'(QDEPTH - 1));

  assign head_vregid = mem_vregid[rd_ptr];
  assign head_val    = mem_val[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the pointers, so stale data is never observed and the RAM stays resetless.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_vregid[wr_ptr] <= push_vregid;
      mem_val[wr_ptr]    <= push_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: buffers results from NSRC functional-unit sources
// and grants up to three per cycle onto the writeback buses, rotating the
// starting priority after every cycle that made a grant.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       synchronous clear (misprediction)
//   src_en/src_vregid/src_val   per-source result push, packed by source index
//   src_afull                   per-source queue almost-full (>= QDEPTH-1)
//   writebackN_en/vregid/val    registered result buses 1..3
//   err_overflow                sticky: a result was dropped
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NSRC   = DEF_NSRC,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NSRC-1:0]        src_en,
  input  logic [NSRC*VREG_W-1:0] src_vregid,
  input  logic [NSRC*XLEN-1:0]   src_val,
  output logic [NSRC-1:0]        src_afull,
  output logic                   writeback1_en,
  output logic [VREG_W-1:0]      writeback1_vregid,
  output logic [XLEN-1:0]        writeback1_val,
  output logic                   writeback2_en,
  output logic [VREG_W-1:0]      writeback2_vregid,
  output logic [XLEN-1:0]        writeback2_val,
  output logic                   writeback3_en,
  output logic [VREG_W-1:0]      writeback3_vregid,
  output logic [XLEN-1:0]        writeback3_val,
  output logic                   err_overflow
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int RR_W  = $clog2(NSRC);

  logic [CNT_W-1:0]  cnt        [NSRC];
  logic [VREG_W-1:0] head_vregid[NSRC];
  logic [XLEN-1:0]   head_val   [NSRC];
  wb_entry_t         cand       [NSRC];
  logic [NSRC-1:0]   grant;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [NSRC-1:0]   ovf;

  wb_entry_t [NUM_WB-1:0] bus_next;
  wb_entry_t [NUM_WB-1:0] wb_q;
  logic [1:0]             n_grant;
  logic [RR_W-1:0]        last_idx;
  logic [RR_W-1:0]        rr;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic nonempty;
    assign nonempty = (cnt[i] != '0);

    // Queue head wins over the incoming result, so a source offers one
    // candidate and its order is preserved.
    assign cand[i].en     = nonempty || src_en[i];
    assign cand[i].vregid = nonempty ? head_vregid[i] : src_vregid[VREG_W*i +: VREG_W];
    assign cand[i].val    = nonempty ? head_val[i]    : src_val[XLEN*i +: XLEN];

    assign pop[i]  = grant[i] && nonempty;
    // An incoming result that was bypassed straight onto a bus is not stored.
    assign push[i] = src_en[i] && !flush && !(grant[i] && !nonempty);

    wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .push        (push[i]),
      .push_vregid (src_vregid[VREG_W*i +: VREG_W]),
      .push_val    (src_val[XLEN*i +: XLEN]),
      .pop         (pop[i]),
      .head_vregid (head_vregid[i]),
      .head_val    (head_val[i]),
      .count       (cnt[i]),
      .afull       (src_afull[i]),
      .overflow    (ovf[i])
    );
  end

  // Rotating scan from rr: the first three candidates fill buses 1..3.
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    logic [RR_W:0]   sum;
    logic [RR_W-1:0] idx;
    grant    = '0;
    bus_next = '0;
    n_grant  = '0;
    last_idx = rr;
    for (int k = 0; k < NSRC; k++) begin
      sum = {1'b0, rr} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(NSRC)) sum = sum - (RR_W+1)'(NSRC);
      idx = sum[RR_W-1:0];
      if (cand[idx].en && (n_grant != 2'(NUM_WB))) begin
        grant[idx]        = 1'b1;
        bus_next[n_grant] = cand[idx];
        n_grant           = n_grant + 1'b1;
        last_idx          = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q         <= '0;
      rr           <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (|ovf) err_overflow <= 1'b1;
      if (flush) begin
        wb_q <= '0;
        rr   <= '0;
      end else begin
        wb_q <= bus_next;
        if (n_grant != '0)
          rr <= (last_idx == RR_W'(NSRC - 1)) ? '0 : last_idx + 1'b1;
      end
    end
  end

  assign writeback1_en     = wb_q[0].en;
  assign writeback1_vregid = wb_q[0].vregid;
  assign writeback1_val    = wb_q[0].val;
  assign writeback2_en     = wb_q[1].en;
  assign writeback2_vregid = wb_q[1].vregid;
  assign writeback2_val    = wb_q[1].val;
  assign writeback3_en     = wb_q[2].en;
  assign writeback3_vregid = wb_q[2].vregid;
  assign writeback3_val    = wb_q[2].val;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NSRC=4, QDEPTH=4). Inputs change 1 ns after
// the rising edge; outputs are checked at that same point.
module tb_wb_arbiter;

  localparam int NSRC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NSRC-1:0]   src_en;
  logic [NSRC*5-1:0] src_vregid;
  logic [NSRC*32-1:0] src_val;
  logic [NSRC-1:0]   src_afull;
  logic              writeback1_en, writeback2_en, writeback3_en;
  logic [4:0]        writeback1_vregid, writeback2_vregid, writeback3_vregid;
  logic [31:0]       writeback1_val, writeback2_val, writeback3_val;
  logic              err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.NSRC(NSRC), .QDEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .src_en            (src_en),
    .src_vregid        (src_vregid),
    .src_val           (src_val),
    .src_afull         (src_afull),
    .writeback1_en     (writeback1_en),
    .writeback1_vregid (writeback1_vregid),
    .writeback1_val    (writeback1_val),
    .writeback2_en     (writeback2_en),
    .writeback2_vregid (writeback2_vregid),
    .writeback2_val    (writeback2_val),
    .writeback3_en     (writeback3_en),
    .writeback3_vregid (writeback3_vregid),
    .writeback3_val    (writeback3_val),
    .err_overflow      (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_en     = '0;
    src_vregid = '0;
    src_val    = '0;
  endtask

  task automatic fire(input int idx, input logic [4:0] vreg, input logic [31:0] val);
    src_en[idx]           = 1'b1;
    src_vregid[5*idx +: 5]  = vreg;
    src_val[32*idx +: 32] = val;
  endtask

  task automatic fire_all(input logic [4:0] base);
    for (int i = 0; i < NSRC; i++) fire(i, base + 5'(i), 32'h100 + 32'(i));
  endtask

  task automatic do_flush();
    clear_src();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    clear_src();
    #12;
    check("reset_wb1_en", 32'(writeback1_en), 0);
    check("reset_wb1_val", writeback1_val, 0);
    check("reset_afull", 32'(src_afull), 0);
    check("reset_err", 32'(err_overflow), 0);
    rst = 1'b0;
    tick();

    // Single uncontested result: one-cycle latency on bus 1.
    fire(2, 5'd7, 32'h1234);
    tick();
    clear_src();
    check("single_wb1_en", 32'(writeback1_en), 1);
    check("single_wb1_vreg", 32'(writeback1_vregid), 7);
    check("single_wb1_val", writeback1_val, 32'h1234);
    check("single_wb2_en", 32'(writeback2_en), 0);
    check("single_wb3_en", 32'(writeback3_en), 0);
    tick();
    check("single_idle_wb1_en", 32'(writeback1_en), 0);

    // Four-way contention from rr=0, repeated to show rr wraps back to 0.
    do_flush();
    check("flush_idle_wb1_en", 32'(writeback1_en), 0);
    for (int rep = 0; rep < 2; rep++) begin
      fire_all(5'(10 + 10*rep));
      tick();
      clear_src();
      check("cont_wb1_vreg", 32'(writeback1_vregid), 32'(10 + 10*rep));
      check("cont_wb2_vreg", 32'(writeback2_vregid), 32'(11 + 10*rep));
      check("cont_wb3_vreg", 32'(writeback3_vregid), 32'(12 + 10*rep));
      check("cont_wb3_val", writeback3_val, 32'h102);
      tick();
      check("cont_tail_wb1_en", 32'(writeback1_en), 1);
      check("cont_tail_wb1_vreg", 32'(writeback1_vregid), 32'(13 + 10*rep));
      check("cont_tail_wb1_val", writeback1_val, 32'h103);
      check("cont_tail_wb2_en", 32'(writeback2_en), 0);
    end

    // Saturation: sources 0/1 every cycle, sources 2/3 once at c=0 (rr=0).
    for (int c = 0; c < 10; c++) begin
      clear_src();
      fire(0, 5'(c), 32'(c));
      fire(1, 5'(16 + c), 32'h200 + 32'(c));
      if (c == 0) begin
        fire(2, 5'd30, 32'h300);
        fire(3, 5'd31, 32'h301);
      end
      tick();
      if (c == 0) begin
        check("sat0_wb1", 32'(writeback1_vregid), 0);
        check("sat0_wb2", 32'(writeback2_vregid), 16);
        check("sat0_wb3", 32'(writeback3_vregid), 30);
      end else if (c == 1) begin
        check("sat1_wb1", 32'(writeback1_vregid), 31);
        check("sat1_wb1_val", writeback1_val, 32'h301);
        check("sat1_wb2", 32'(writeback2_vregid), 1);
        check("sat1_wb3", 32'(writeback3_vregid), 17);
      end else begin
        check("sat_wb1", 32'(writeback1_vregid), 32'(c));
        check("sat_wb2", 32'(writeback2_vregid), 32'(16 + c));
        check("sat_wb2_val", writeback2_val, 32'h200 + 32'(c));
        check("sat_wb3_en", 32'(writeback3_en), 0);
      end
    end
    clear_src();
    check("sat_no_drop", 32'(err_overflow), 0);

    // Overflow: all sources every cycle from rr=0. Queue 3 reaches 3 entries
    // after c=8, queue 0 after c=11; source 3 first drops at c=16.
    do_flush();
    for (int c = 0; c < 17; c++) begin
      fire_all(5'(c));
      tick();
      if (c == 7)  check("ovf_afull_c7", 32'(src_afull), 32'b0000);
      if (c == 8)  check("ovf_afull_c8", 32'(src_afull), 32'b1000);
      if (c == 11) check("ovf_afull_c11", 32'(src_afull), 32'b1111);
      if (c == 15) check("ovf_err_c15", 32'(err_overflow), 0);
      if (c == 16) check("ovf_err_c16", 32'(err_overflow), 1);
    end
    do_flush();
    check("ovf_err_after_flush", 32'(err_overflow), 1);
    check("ovf_afull_after_flush", 32'(src_afull), 0);

    // Flush with queued entries: source 1 holds 3 after c=10.
    for (int c = 0; c < 11; c++) begin
      fire_all(5'(c));
      tick();
    end
    check("flush_pre_afull", 32'(src_afull), 32'b1110);
    fire_all(5'd25);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_src();
    check("flush_wb1_en", 32'(writeback1_en), 0);
    check("flush_wb2_en", 32'(writeback2_en), 0);
    check("flush_wb3_en", 32'(writeback3_en), 0);
    check("flush_afull", 32'(src_afull), 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("flush_stale_en", 32'({writeback1_en, writeback2_en, writeback3_en}), 0);
    end

    // Asynchronous reset while a bus is active.
    fire(0, 5'd5, 32'hAA);
    tick();
    clear_src();
    check("arst_pre_wb1_en", 32'(writeback1_en), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_wb1_en", 32'(writeback1_en), 0);
    check("arst_wb1_val", writeback1_val, 0);
    check("arst_err", 32'(err_overflow), 0);
    #2 rst = 1'b0;
    fire_all(5'h10);
    tick();
    clear_src();
    check("arst_rr_wb1", 32'(writeback1_vregid), 32'h10);
    check("arst_rr_wb3", 32'(writeback3_vregid), 32'h12);
    tick();
    check("arst_tail_wb1", 32'(writeback1_vregid), 32'h13);
    fire(1, 5'd9, 32'h55);
    tick();
    clear_src();
    check("arst_single_en", 32'(writeback1_en), 1);
    check("arst_single_vreg", 32'(writeback1_vregid), 9);
    check("arst_single_val", writeback1_val, 32'h55);
    check("arst_single_wb2_en", 32'(writeback2_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
